// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the external memory bus arbiter: the FSM state encoding
// and the width of the multiplexed address/data bus.
package mem_bus_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Picks one requester per arbitration slot, either by rotating priority from a
// pointer or by fixed lowest-index-wins priority, and reports the pointer to use next.
module rr_arbiter #(
  parameter int NREQ        = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  input  logic                    i_en,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_nextPtr
);

  localparam int PW = $clog2(NREQ);

  logic          w_found;
  logic [PW-1:0] w_idx;
  int            w_base;

  // Scan upward from the base index with wrap; fixed priority always scans from 0.
  always_comb begin
    o_grant   = '0;
    o_nextPtr = i_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    w_base    = (ROUND_ROBIN != 0) ? int'(i_ptr) : 0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = PW'((w_base + off) % NREQ);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        o_nextPtr      = PW'((w_base + off + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single 8-bit multiplexed external memory port between NREQ
// requesters using a fixed ADDR/DATA two-cycle exchange per transaction.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [BUS_W*NREQ-1:0] addr,
  input  logic [BUS_W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [BUS_W-1:0]      rdata,
  output logic [BUS_W-1:0]      mem_out,
  input  logic [BUS_W-1:0]      mem_in,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  state_t           r_state;
  state_t           w_stateNext;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_winIdx;
  logic             r_we;
  logic [BUS_W-1:0] r_addr;
  logic [BUS_W-1:0] r_wdata;
  logic [BUS_W-1:0] r_rdata;
  logic [NREQ-1:0]  r_done;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_nextPtr;
  logic [PW-1:0]    w_winIdx;
  logic             w_winWe;
  logic [BUS_W-1:0] w_winAddr;
  logic [BUS_W-1:0] w_winWdata;
  logic             w_arbEn;
  logic             w_anyGrant;

  // The last DATA cycle arbitrates too, so a waiting request goes straight to ADDR.
  assign w_arbEn    = (r_state == IDLE) || (r_state == DATA);
  assign w_anyGrant = |w_grant;

  rr_arbiter #(
    .NREQ        (NREQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .i_en      (w_arbEn),
    .o_grant   (w_grant),
    .o_nextPtr (w_nextPtr)
  );

  always_comb begin
    w_winIdx   = '0;
    w_winWe    = 1'b0;
    w_winAddr  = '0;
    w_winWdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_winIdx   = PW'(i);
        w_winWe    = we[i];
        w_winAddr  = addr[BUS_W*i +: BUS_W];
        w_winWdata = wdata[BUS_W*i +: BUS_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    gnt         = '0;
    mem_out     = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyGrant) w_stateNext = ADDR;
      end
      ADDR: begin
        w_stateNext = DATA;
        gnt         = NREQ'(1'b1) << r_winIdx;
        mem_out     = r_addr;
        mem_read    = ~r_we;
        mem_write   = r_we;
        busy        = 1'b1;
      end
      DATA: begin
        w_stateNext = w_anyGrant ? ADDR : IDLE;
        mem_out     = r_we ? r_wdata : '0;
        busy        = 1'b1;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Reset drops r_done, so a transaction cut short never reports completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_winIdx <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_done   <= '0;
    end else begin
      r_ptr  <= w_nextPtr;
      r_done <= (r_state == DATA) ? (NREQ'(1'b1) << r_winIdx) : '0;
      if (w_anyGrant) begin
        r_winIdx <= w_winIdx;
        r_we     <= w_winWe;
        r_addr   <= w_winAddr;
        r_wdata  <= w_winWdata;
      end
      if ((r_state == DATA) && !r_we) begin
        r_rdata <= mem_in;
      end
    end
  end

  assign done  = r_done;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a rotating-priority and a fixed-priority arbiter share one set
// of requester inputs; expected values are hand-computed per cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [7:0]  memIn;

  logic [1:0]  rrGnt, rrDone, fpGnt, fpDone;
  logic [7:0]  rrRdata, rrMemOut, fpRdata, fpMemOut;
  logic        rrMemRead, rrMemWrite, rrBusy, fpMemRead, fpMemWrite, fpBusy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NREQ(2), .ROUND_ROBIN(1)) dutRr (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(rrGnt), .done(rrDone), .rdata(rrRdata), .mem_out(rrMemOut), .mem_in(memIn),
    .mem_read(rrMemRead), .mem_write(rrMemWrite), .busy(rrBusy)
  );

  mem_bus_arbiter #(.NREQ(2), .ROUND_ROBIN(0)) dutFp (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(fpGnt), .done(fpDone), .rdata(fpRdata), .mem_out(fpMemOut), .mem_in(memIn),
    .mem_read(fpMemRead), .mem_write(fpMemWrite), .busy(fpBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [15:0] a, input logic [15:0] d);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".gnt"}, 32'(rrGnt), 32'd0);
    checkOutput({tag, ".done"}, 32'(rrDone), 32'd0);
    checkOutput({tag, ".memOut"}, 32'(rrMemOut), 32'd0);
    checkOutput({tag, ".memRead"}, 32'(rrMemRead), 32'd0);
    checkOutput({tag, ".memWrite"}, 32'(rrMemWrite), 32'd0);
    checkOutput({tag, ".busy"}, 32'(rrBusy), 32'd0);
    checkOutput({tag, ".fpBusy"}, 32'(fpBusy), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    memIn = 8'h00;
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    repeat (2) nextCycle();
    checkQuiet("reset");
    checkOutput("reset.rdata", 32'(rrRdata), 32'd0);
    rst_n = 1'b1;
    nextCycle();

    // Single read by requester 0
    applyStimulus(2'b01, 2'b00, 16'h0012, 16'h0000);
    nextCycle();
    checkOutput("rd.gnt", 32'(rrGnt), 32'h1);
    checkOutput("rd.memOut", 32'(rrMemOut), 32'h12);
    checkOutput("rd.memRead", 32'(rrMemRead), 32'd1);
    checkOutput("rd.memWrite", 32'(rrMemWrite), 32'd0);
    checkOutput("rd.busyAddr", 32'(rrBusy), 32'd1);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("rd.dataMemOut", 32'(rrMemOut), 32'h0);
    checkOutput("rd.dataStrobes", 32'({rrMemRead, rrMemWrite}), 32'h0);
    checkOutput("rd.dataGnt", 32'(rrGnt), 32'h0);
    checkOutput("rd.busyData", 32'(rrBusy), 32'd1);
    memIn = 8'h5A;
    nextCycle();
    checkOutput("rd.done", 32'(rrDone), 32'h1);
    checkOutput("rd.rdata", 32'(rrRdata), 32'h5A);
    checkOutput("rd.busyEnd", 32'(rrBusy), 32'd0);
    memIn = 8'h00;

    // Single write by requester 1
    applyStimulus(2'b10, 2'b10, 16'h8000, 16'hC300);
    nextCycle();
    checkOutput("wr.gnt", 32'(rrGnt), 32'h2);
    checkOutput("wr.memOut", 32'(rrMemOut), 32'h80);
    checkOutput("wr.memWrite", 32'(rrMemWrite), 32'd1);
    checkOutput("wr.memRead", 32'(rrMemRead), 32'd0);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("wr.dataMemOut", 32'(rrMemOut), 32'hC3);
    checkOutput("wr.dataStrobes", 32'({rrMemRead, rrMemWrite}), 32'h0);
    memIn = 8'hFF;
    nextCycle();
    checkOutput("wr.done", 32'(rrDone), 32'h2);
    checkOutput("wr.rdataKept", 32'(rrRdata), 32'h5A);
    memIn = 8'h00;

    // Both requesting continuously: rotating priority alternates, fixed stays on 0
    applyStimulus(2'b11, 2'b00, 16'h2211, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checkOutput($sformatf("rr.gnt%0d", k), 32'(rrGnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("rr.done%0d", k), 32'(rrDone),
                  (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
      checkOutput($sformatf("rr.busyA%0d", k), 32'(rrBusy), 32'd1);
      checkOutput($sformatf("rr.fpGnt%0d", k), 32'(fpGnt), 32'h1);
      if (k == 3) applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      nextCycle();
      checkOutput($sformatf("rr.gapGnt%0d", k), 32'(rrGnt), 32'h0);
      checkOutput($sformatf("rr.busyD%0d", k), 32'(rrBusy), 32'd1);
    end
    nextCycle();
    checkOutput("rr.lastDone", 32'(rrDone), 32'h2);
    checkOutput("rr.idle", 32'(rrBusy), 32'd0);
    nextCycle();

    // Fixed priority: requester 0 keeps winning until it drops out
    applyStimulus(2'b11, 2'b00, 16'h2211, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("fp.gnt%0d", k), 32'(fpGnt), 32'h1);
      if (k == 2) applyStimulus(2'b10, 2'b00, 16'h2211, 16'h0000);
      nextCycle();
    end
    nextCycle();
    checkOutput("fp.gntAfterDrop", 32'(fpGnt), 32'h2);
    checkOutput("fp.doneOverlap", 32'(fpDone), 32'h1);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("fp.done1", 32'(fpDone), 32'h2);
    checkOutput("fp.idle", 32'(fpBusy), 32'd0);
    nextCycle();

    // Back-to-back reads: done of the first overlaps gnt of the second
    applyStimulus(2'b01, 2'b00, 16'h0021, 16'h0000);
    nextCycle();
    checkOutput("b2b.gnt0", 32'(rrGnt), 32'h1);
    checkOutput("b2b.addr0", 32'(rrMemOut), 32'h21);
    applyStimulus(2'b10, 2'b00, 16'h3400, 16'h0000);
    nextCycle();
    memIn = 8'hA5;
    nextCycle();
    checkOutput("b2b.done0", 32'(rrDone), 32'h1);
    checkOutput("b2b.gnt1", 32'(rrGnt), 32'h2);
    checkOutput("b2b.rdata0", 32'(rrRdata), 32'hA5);
    checkOutput("b2b.addr1", 32'(rrMemOut), 32'h34);
    checkOutput("b2b.read1", 32'(rrMemRead), 32'd1);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    memIn = 8'h3C;
    nextCycle();
    nextCycle();
    checkOutput("b2b.done1", 32'(rrDone), 32'h2);
    checkOutput("b2b.rdata1", 32'(rrRdata), 32'h3C);
    checkOutput("b2b.gntEnd", 32'(rrGnt), 32'h0);
    memIn = 8'h00;
    nextCycle();

    // Reset during DATA with requester 1 waiting
    applyStimulus(2'b01, 2'b00, 16'h0044, 16'h0000);
    nextCycle();
    checkOutput("rst.gnt0", 32'(rrGnt), 32'h1);
    applyStimulus(2'b10, 2'b00, 16'h5500, 16'h0000);
    nextCycle();
    checkOutput("rst.busyData", 32'(rrBusy), 32'd1);
    memIn = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    checkQuiet("rst.async");
    checkOutput("rst.asyncRdata", 32'(rrRdata), 32'd0);
    nextCycle();
    checkQuiet("rst.hold");
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rst.gnt1", 32'(rrGnt), 32'h2);
    checkOutput("rst.addr1", 32'(rrMemOut), 32'h55);
    checkOutput("rst.fpGnt1", 32'(fpGnt), 32'h2);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    memIn = 8'h66;
    nextCycle();
    nextCycle();
    checkOutput("rst.done1", 32'(rrDone), 32'h2);
    checkOutput("rst.rdata1", 32'(rrRdata), 32'h66);
    memIn = 8'h00;
    nextCycle();

    // Pointer restarts at 0: reset after granting 0 (pointer would be 1), then contend
    applyStimulus(2'b01, 2'b00, 16'h0099, 16'h0000);
    nextCycle();
    checkOutput("ptr.gnt0", 32'(rrGnt), 32'h1);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    nextCycle();
    #2 rst_n = 1'b0;
    #1;
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b00, 16'hBBAA, 16'h0000);
    nextCycle();
    checkOutput("ptr.restartGnt", 32'(rrGnt), 32'h1);
    checkOutput("ptr.restartAddr", 32'(rrMemOut), 32'hAA);
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("ptr.done", 32'(rrDone), 32'h1);
    checkOutput("ptr.idle", 32'(rrBusy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
